// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter
// ----------------------------------------------------------------------------
// Two-requester, packet-granular arbiter in front of a single UART transmitter.
// Once a requester is granted it owns the transmitter until it hands over a
// byte marked "last". Ties in IDLE are broken round-robin via last_served, and
// every release passes through at least one IDLE cycle before the next grant.
//
// While a requester owns the link, its valid/data/ready are a zero-latency
// combinational pass-through to the transmitter. The other requester sees
// ready=0 and simply keeps its request pending.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, an idle counter runs while the owner is mid-packet with its
//   valid low. After TIMEOUT_CYCLES such cycles the grant is forcibly released
//   and 'timeout' pulses for one cycle. When undefined, no counter is built,
//   the grant is held until a last-byte handshake, and 'timeout' is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles mid-packet before forced release
//                   (only meaningful with UART_ARB_TIMEOUT_EN)
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    synchronous active-high reset
//   req0_valid/data/last     requester 0 byte stream, req0_ready back
//   req1_valid/data/last     requester 1 byte stream, req1_ready back
//   tx_valid/tx_data         byte offered to the UART transmitter
//   tx_ready                 transmitter accepts the offered byte
//   grant[1:0]               one-hot owner (bit0 = req0, bit1 = req1, 00 = none)
//   timeout                  one-cycle pulse on a forced release
// ============================================================================
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,

    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,

    output logic [1:0] grant,
    output logic       timeout
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Index of the requester granted most recently; the opposite one wins a tie.
    logic   last_served_reg;
    logic   last_served_next;

    // ------------------------------------------------------------------------
    // Requester ports gathered into vectors so both lanes share one datapath
    // ------------------------------------------------------------------------
    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [1:0] req_ready;
    logic [7:0] req_data    [2];
    logic [7:0] data_masked [2];

    logic [1:0] grant_vec;
    logic       handshake;
    logic       release_last;
    logic       expire;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_last    = {req1_last,  req0_last};
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Grant is a pure decode of the state register. Keeping it separate from
    // the next-state logic avoids a combinational path from the pass-through
    // back into the process that produces the grant.
    always_comb begin
        grant_vec = 2'b00;
        unique case (state_reg)
            GRANT0:  grant_vec = 2'b01;
            GRANT1:  grant_vec = 2'b10;
            default: grant_vec = 2'b00;
        endcase
    end

    // Per-lane pass-through: only the owner lane sees tx_ready, and only the
    // owner's data reaches the AND-OR mux. With no owner everything is zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign req_ready[gi]   = grant_vec[gi] & tx_ready;
            assign data_masked[gi] = req_data[gi] & {8{grant_vec[gi]}};
        end
    endgenerate

    assign tx_data      = data_masked[0] | data_masked[1];
    assign tx_valid     = |(grant_vec & req_valid);
    assign req0_ready   = req_ready[0];
    assign req1_ready   = req_ready[1];
    assign grant        = grant_vec;

    assign handshake    = tx_valid & tx_ready;
    assign release_last = handshake & (|(grant_vec & req_last));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            last_served_reg <= 1'b1;    // req0 wins the first tie after reset
        end else begin
            state_reg       <= state_next;
            last_served_reg <= last_served_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // Arbitration happens only in IDLE, so a release always costs one IDLE
    // cycle before the next owner is chosen.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        last_served_next = last_served_reg;

        unique case (state_reg)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    if (last_served_reg) begin
                        state_next       = GRANT0;
                        last_served_next = 1'b0;
                    end else begin
                        state_next       = GRANT1;
                        last_served_next = 1'b1;
                    end
                end else if (req_valid[0]) begin
                    state_next       = GRANT0;
                    last_served_next = 1'b0;
                end else if (req_valid[1]) begin
                    state_next       = GRANT1;
                    last_served_next = 1'b1;
                end
            end

            GRANT0, GRANT1: begin
                if (release_last || expire) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional mid-packet idle timeout
    // ------------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt_reg;
    logic [CNT_W-1:0] idle_cnt_next;
    logic             timeout_reg;

    // The counter only advances while the owner has nothing to offer. A stall
    // caused by tx_ready=0 keeps valid high and therefore never counts. When
    // valid returns without a handshake the count is held, not cleared; only
    // a completed byte or a return to IDLE resets it.
    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        expire        = 1'b0;
        if ((state_reg == IDLE) || handshake) begin
            idle_cnt_next = '0;
        end else if (!tx_valid) begin
            if (idle_cnt_reg == CNT_LAST) begin
                expire        = 1'b1;
                idle_cnt_next = '0;
            end else begin
                idle_cnt_next = idle_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            timeout_reg  <= expire;     // high in the first IDLE cycle after release
        end
    end

    assign timeout = timeout_reg;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;

    // TIMEOUT_CYCLES stays on the interface so both builds drop into the same
    // sockets; without the timeout feature it has no hardware behind it.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
        end
    endgenerate
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter
// Directed scenarios followed by randomized packet traffic on both requesters.
// A transaction-level reference model (owner / last_served / idle run length)
// predicts grant, pass-through and timeout each cycle.
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       v [2];
    logic [7:0] d [2];
    logic       l [2];
    logic       tx_ready;

    logic       req0_ready, req1_ready, tx_valid, timeout;
    logic [7:0] tx_data;
    logic [1:0] grant;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (v[0]),
        .req0_data  (d[0]),
        .req0_last  (l[0]),
        .req0_ready (req0_ready),
        .req1_valid (v[1]),
        .req1_data  (d[1]),
        .req1_last  (l[1]),
        .req1_ready (req1_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .grant      (grant),
        .timeout    (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    string phase = "init";

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;   // -1 none, else requester index
    int m_last  = 1;    // last served requester
    int m_idle  = 0;    // consecutive owner-idle cycles within a packet
    bit m_tmo   = 1'b0; // timeout pulse expected this cycle
    bit hs [2];

    logic [1:0] obs_grant;
    logic       obs_txv, obs_r0, obs_r1, obs_tmo;
    logic [7:0] obs_txd;

    task automatic model_check();
        logic [1:0] eg;
        logic       etv, er0, er1;
        logic [7:0] etd;
        bit         ow;
        eg = 2'b00; etv = 1'b0; etd = 8'h00; er0 = 1'b0; er1 = 1'b0;
        if (m_owner >= 0) begin
            ow  = 1'(m_owner);
            eg  = ow ? 2'b10 : 2'b01;
            etv = v[ow];
            etd = d[ow];
            if (ow) er1 = tx_ready; else er0 = tx_ready;
        end
        obs_grant = grant; obs_txv = tx_valid; obs_txd = tx_data;
        obs_r0 = req0_ready; obs_r1 = req1_ready; obs_tmo = timeout;
        check_eq({phase, "/grant"},   32'(obs_grant), 32'(eg));
        check_eq({phase, "/tx_valid"}, 32'(obs_txv), 32'(etv));
        check_eq({phase, "/tx_data"}, 32'(obs_txd), 32'(etd));
        check_eq({phase, "/ready0"},  32'(obs_r0), 32'(er0));
        check_eq({phase, "/ready1"},  32'(obs_r1), 32'(er1));
        check_eq({phase, "/timeout"}, 32'(obs_tmo), 32'(m_tmo));
    endtask

    task automatic model_update();
        bit ow;
        hs[0] = 1'b0; hs[1] = 1'b0;
        if (reset) begin
            m_owner = -1; m_last = 1; m_idle = 0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                m_idle = 0;
                if (v[0] && v[1])  m_owner = 1 - m_last;
                else if (v[0])     m_owner = 0;
                else if (v[1])     m_owner = 1;
                if (m_owner >= 0)  m_last = m_owner;
            end else begin
                ow = 1'(m_owner);
                if (v[ow] && tx_ready) begin
                    hs[ow] = 1'b1;
                    m_idle = 0;
                    if (l[ow]) begin
                        $display("[TB] %s: req%0d packet complete, last byte %02h", phase, m_owner, d[ow]);
                        m_owner = -1;
                    end
                end else if (!v[ow]) begin
`ifdef UART_ARB_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == TMO) begin
                        $display("[TB] %s: req%0d forced release after %0d idle cycles", phase, m_owner, TMO);
                        m_owner = -1;
                        m_tmo   = 1'b1;
                        m_idle  = 0;
                    end
`endif
                end
            end
        end
    endtask

    // ---------------- random traffic generator ----------------
    bit         auto_mode = 1'b0;
    int         plen [2];
    int         ppos [2];
    int         pgap [2];
    logic [7:0] pbytes [2][8];

    task automatic new_pkt(input int i);
        plen[i] = $urandom_range(1, 6);
        ppos[i] = 0;
        for (int k = 0; k < 8; k++) pbytes[i][k] = 8'($urandom);
        pgap[i] = $urandom_range(0, 6);
    endtask

    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                ppos[i]++;
                if (ppos[i] == plen[i]) new_pkt(i);
                else pgap[i] = $urandom_range(0, 3);   // short mid-packet gap
            end else if (!v[i] && pgap[i] > 0) begin
                pgap[i]--;
            end
            v[i] = (pgap[i] == 0);
            d[i] = pbytes[i][ppos[i]];
            l[i] = (ppos[i] == plen[i] - 1);
        end
        tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        if (auto_mode) drive_random();
    endtask

    task automatic idle_inputs();
        v[0] = 1'b0; v[1] = 1'b0; d[0] = 8'h00; d[1] = 8'h00;
        l[0] = 1'b0; l[1] = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        check_eq("reset/grant",   32'(obs_grant), 32'h0);
        check_eq("reset/txvalid", 32'(obs_txv),   32'h0);
        check_eq("reset/timeout", 32'(obs_tmo),   32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();

        // ---- 3-byte packet from req0 ----
        phase = "pkt3";
        reset_dut();
        v[0] = 1'b1; d[0] = 8'h41; tx_ready = 1'b1;
        step();
        check_eq("pkt3/arb_cycle_grant", 32'(obs_grant), 32'h0);
        step();
        check_eq("pkt3/grant", 32'(obs_grant), 32'h1);
        check_eq("pkt3/byte0", 32'(obs_txd), 32'h41);
        d[0] = 8'h42;
        step();
        check_eq("pkt3/byte1", 32'(obs_txd), 32'h42);
        d[0] = 8'h43; l[0] = 1'b1;
        step();
        check_eq("pkt3/byte2", 32'(obs_txd), 32'h43);
        v[0] = 1'b0; l[0] = 1'b0;
        step();
        check_eq("pkt3/release", 32'(obs_grant), 32'h0);

        // ---- tie after reset: req0 first, then req1 after an IDLE cycle ----
        phase = "tie";
        reset_dut();
        v[0] = 1'b1; d[0] = 8'hA0; l[0] = 1'b1;
        v[1] = 1'b1; d[1] = 8'hB0; l[1] = 1'b1;
        tx_ready = 1'b1;
        step();
        step();
        check_eq("tie/first_owner", 32'(obs_grant), 32'h1);
        check_eq("tie/first_data",  32'(obs_txd),   32'hA0);
        v[0] = 1'b0;
        step();
        check_eq("tie/gap_cycle", 32'(obs_grant), 32'h0);
        step();
        check_eq("tie/second_owner", 32'(obs_grant), 32'h2);
        check_eq("tie/second_data",  32'(obs_txd),   32'hB0);
        v[1] = 1'b0;
        step();

        // ---- req1 arrives mid-packet of req0 ----
        phase = "midpkt";
        reset_dut();
        v[0] = 1'b1; d[0] = 8'h11; tx_ready = 1'b1;
        step();
        v[1] = 1'b1; d[1] = 8'h99; l[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("midpkt/ready1_low", 32'(obs_r1),  32'h0);
            check_eq("midpkt/owner_data", 32'(obs_txd), 32'(8'h11 + k));
            d[0] = 8'(8'h12 + k);
            l[0] = (k == 1);
        end
        v[0] = 1'b0; l[0] = 1'b0;
        step();
        check_eq("midpkt/gap", 32'(obs_grant), 32'h0);
        step();
        check_eq("midpkt/req1_grant", 32'(obs_grant), 32'h2);
        check_eq("midpkt/req1_data",  32'(obs_txd),   32'h99);
        v[1] = 1'b0;
        step();

        // ---- tx_ready stalled 50 cycles with owner valid ----
        phase = "stall";
        reset_dut();
        v[0] = 1'b1; d[0] = 8'h55; l[0] = 1'b1; tx_ready = 1'b0;
        step();
        for (int k = 0; k < 50; k++) begin
            step();
            check_eq("stall/grant_held", 32'(obs_grant), 32'h1);
            check_eq("stall/data_stable", 32'(obs_txd), 32'h55);
            check_eq("stall/no_timeout", 32'(obs_tmo), 32'h0);
        end
        tx_ready = 1'b1;
        step();
        v[0] = 1'b0; l[0] = 1'b0;
        step();
        check_eq("stall/release", 32'(obs_grant), 32'h0);

        // ---- owner drops valid mid-packet ----
        phase = "drop";
        reset_dut();
        v[0] = 1'b1; d[0] = 8'h21; tx_ready = 1'b1;
        step();
        step();
        v[0] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int  held = 0;
            bit  seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                step();
                if (obs_grant == 2'b00) seen = 1'b1;
                else held++;
            end
            check_eq("drop/release_seen", 32'(seen), 32'h1);
            check_eq("drop/cycles_held", 32'(held), 32'(TMO));
            check_eq("drop/timeout_pulse", 32'(obs_tmo), 32'h1);
            step();
            check_eq("drop/timeout_single", 32'(obs_tmo), 32'h0);
        end
`else
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq("drop/grant_held", 32'(obs_grant), 32'h1);
            check_eq("drop/no_timeout", 32'(obs_tmo), 32'h0);
        end
        v[0] = 1'b1; d[0] = 8'h22; l[0] = 1'b1;
        step();
        v[0] = 1'b0; l[0] = 1'b0;
        step();
        check_eq("drop/release", 32'(obs_grant), 32'h0);
`endif

        // ---- reset during GRANT1, then tie goes to req0 ----
        phase = "rst_g1";
        reset_dut();
        v[1] = 1'b1; d[1] = 8'h77;
        step();
        step();
        check_eq("rst_g1/owner1", 32'(obs_grant), 32'h2);
        reset = 1'b1;
        v[0] = 1'b1; d[0] = 8'h66; l[0] = 1'b1;
        step();
        step();
        check_eq("rst_g1/grant_dropped", 32'(obs_grant), 32'h0);
        check_eq("rst_g1/txvalid_low",   32'(obs_txv),   32'h0);
        reset = 1'b0;
        step();
        step();
        check_eq("rst_g1/tie_req0", 32'(obs_grant), 32'h1);
        check_eq("rst_g1/tie_data", 32'(obs_txd),   32'h66);

        // ---- randomized traffic ----
        phase = "random";
        reset_dut();
        new_pkt(0);
        new_pkt(1);
        hs[0] = 1'b0; hs[1] = 1'b0;
        auto_mode = 1'b1;
        drive_random();
        for (int k = 0; k < 3000; k++) step();
        auto_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, the idle cycles mid-packet before forced release (used only with UART_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1, requester 0 has a byte.
REQ-005 The block SHALL have port req0_data, input, 8, requester 0 byte.
REQ-006 The block SHALL have port req0_last, input, 1, the byte ends requester 0's packet.
REQ-007 The block SHALL have port req0_ready, output, 1, requester 0 byte accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_data, req1_last and req1_ready, identical to REQ-004..REQ-007, for requester 1.
REQ-009 The block SHALL have port tx_valid, output, 1, byte offered to the UART transmitter.
REQ-010 The block SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-011 The block SHALL have port tx_ready, input, 1, the UART transmitter accepts the byte.
REQ-012 The block SHALL have port grant, output, 2, one-hot current owner (bit0 = req0, bit1 = req1, 00 = none).
REQ-013 The block SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT0 and GRANT1; grant SHALL be 01 in GRANT0, 10 in GRANT1, and 00 in IDLE.
REQ-015 In IDLE, with exactly one reqN_valid high, the FSM SHALL move to GRANTN on the next edge (one cycle arbitration latency).
REQ-016 In IDLE, with both valids high, the FSM SHALL grant the requester not recorded in the last_served register (round-robin).
REQ-017 last_served SHALL update to N on entry to GRANTN.
REQ-018 In GRANTN, tx_valid, tx_data and reqN_ready SHALL be a combinational pass-through: tx_valid=reqN_valid, tx_data=reqN_data, reqN_ready=tx_ready, all with zero latency.
REQ-019 The non-granted requester's ready SHALL be 0.
REQ-020 In IDLE, tx_valid, req0_ready and req1_ready SHALL be 0, and tx_data SHALL be 8'h00.
REQ-021 A handshake (reqN_valid & tx_ready in GRANTN) with reqN_last=1 SHALL return the FSM to IDLE on the next edge.
REQ-022 No re-grant SHALL occur in the same cycle as the REQ-021 release, so there is always at least one IDLE cycle between packets.
REQ-023 A handshake with reqN_last=0 SHALL keep the grant; the packet holds ownership across any number of bytes.
REQ-024 Requests from the non-owner SHALL be ignored while held, with no loss: its valid stays pending and no ready is given.
REQ-025 After a packet from N completes, if both requesters are waiting, the other requester SHALL be granted next.

Reset
REQ-026 On reset, the state SHALL be IDLE, last_served SHALL be 1 (so req0 wins the first tie), grant SHALL be 00, timeout SHALL be 0, and the idle counter SHALL be 0.
REQ-027 Reset asserted mid-packet SHALL drop the grant at that edge, and the partial packet SHALL be abandoned without completion.
REQ-028 All outputs SHALL remain at their reset values while reset is high.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in GRANTN with reqN_valid=0.
REQ-030 With UART_ARB_TIMEOUT_EN defined, the counter SHALL clear on every handshake and on IDLE entry.
REQ-031 With UART_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES-1 the FSM SHALL enter IDLE on the next edge and pulse timeout for one cycle.
REQ-032 Without UART_ARB_TIMEOUT_EN, the grant SHALL be held until a last handshake, timeout SHALL be tied 0, and no counter SHALL exist.
REQ-033 The counter SHALL never run while reqN_valid=1, so an owner stalled only by tx_ready=0 is never released.

Verification
REQ-034 Reset, then req0_valid=1 with a 3-byte packet (0x41, 0x42, 0x43 with last) and tx_ready=1 -> grant=01 one cycle later, tx_data sequence 41/42/43, then grant=00.
REQ-035 Both valid in the same IDLE cycle after reset -> req0 is served first; then req1 is granted after one IDLE cycle.
REQ-036 req1 raises valid mid-packet of req0 -> req1_ready stays 0 and tx_data never shows a req1 byte until req0's last byte.
REQ-037 tx_ready held 0 for 50 cycles while owner valid=1 -> no release, tx_data stable, timeout=0.
REQ-038 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, owner drops valid mid-packet -> exactly 8 cycles later grant=00 and timeout pulses for one cycle.
REQ-039 Reset asserted during GRANT1 -> grant=00 and tx_valid=0 on the next edge; after release, req0 wins a tie.
